// File: rtl/evict_sink.sv
// evict_sink: buffers 224-bit eviction records from the last heap stage and exposes them
// to a host over an ack-handshaked localbus (status, head record words, pop, drop stats).
// Optional feature macro: EVICT_SINK_DROPCNT_EN adds a saturating 32-bit drop counter at 0x9.
// Ports:
//   Clk              - system clock, everything on posedge
//   Reset_N          - synchronous reset, active high despite the name
//   Evict_in_key     - record {KEY[223:96], FREQ[95:64], TIMESTAMP[63:32], VALUE[31:0]}
//   Evict_in_key_wr  - one-cycle write strobe for Evict_in_key
//   Evict_in_key_alf - registered almost-full back-pressure
//   local_cs_n/rw/addr/wdata - localbus request (cs active low, rw 1 = read)
//   local_rdata      - read data, valid during the ack cycle and held until the next read
//   local_ack_n      - one-cycle active-low completion strobe
module evict_sink #(
    parameter int DEPTH_LOG2 = 4,
    parameter int ALF_THRESH = 12
) (
    input  logic         Clk,
    input  logic         Reset_N,
    input  logic [223:0] Evict_in_key,
    input  logic         Evict_in_key_wr,
    output logic         Evict_in_key_alf,
    input  logic         local_cs_n,
    input  logic         local_rw,
    input  logic [13:0]  local_addr,
    input  logic [31:0]  local_wdata,
    output logic [31:0]  local_rdata,
    output logic         local_ack_n
);
    localparam int DEPTH = 1 << DEPTH_LOG2;
    typedef enum logic [1:0] {IDLE, ACK, WAIT_REL} state_t;
    state_t                r_state, w_state_nx;
    logic [223:0]          r_mem [DEPTH];
    logic [DEPTH_LOG2-1:0] r_head, r_tail;
    logic [DEPTH_LOG2:0]   r_count;
    logic                  r_ovf, r_alf;
    logic [31:0]           r_rdata, w_rdata, w_dropcnt;
    logic                  w_access, w_wr_acc, w_pop, w_push, w_drop, w_clr, w_empty, w_full;
    logic [255:0]          w_head_rec;
    logic [2:0]            w_sel;
    logic                  w_unused;

    // write data carries no information: every write is a command selected by address
    assign w_unused   = ^local_wdata;
    // the access executes on the edge that leaves IDLE
    assign w_access   = r_state == IDLE && !local_cs_n;
    assign w_wr_acc   = w_access && !local_rw;
    assign w_empty    = r_count == '0;
    assign w_full     = r_count == (DEPTH_LOG2+1)'(DEPTH);
    assign w_pop      = w_wr_acc && local_addr == 14'h8 && !w_empty;
    assign w_clr      = w_wr_acc && local_addr == 14'h9;
    // a same-cycle pop frees the slot the push needs, even when full
    assign w_push     = Evict_in_key_wr && (!w_full || w_pop);
    assign w_drop     = Evict_in_key_wr && !w_push;
    // word 1 is the top 32 bits of the record, word 7 the bottom; padding keeps the slice in range
    assign w_sel      = 3'd7 - local_addr[2:0];
    assign w_head_rec = {32'd0, r_mem[r_head]};

`ifdef EVICT_SINK_DROPCNT_EN
    logic [31:0] r_dropcnt;
    always_ff @(posedge Clk)
        if (Reset_N)
            r_dropcnt <= '0;
        else if (w_clr)
            r_dropcnt <= {31'd0, w_drop};
        else if (w_drop && r_dropcnt != '1)
            r_dropcnt <= r_dropcnt + 32'd1;
    assign w_dropcnt = r_dropcnt;
`else
    assign w_dropcnt = '0;
`endif

    always_comb
        w_rdata = local_addr == 14'h0 ? {r_ovf, 15'd0, 16'(r_count)}
                : local_addr <= 14'h7 ? (w_empty ? '0 : w_head_rec[{w_sel, 5'd0} +: 32])
                : local_addr == 14'h9 ? w_dropcnt
                : '0;

    always_ff @(posedge Clk)
        if (w_push)
            r_mem[r_tail] <= Evict_in_key;

    always_ff @(posedge Clk)
        if (Reset_N) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
            r_ovf   <= 1'b0;
            r_alf   <= 1'b0;
            r_rdata <= '0;
        end else begin
            if (w_pop)
                r_head <= r_head + 1'b1;
            if (w_push)
                r_tail <= r_tail + 1'b1;
            r_count <= r_count + (DEPTH_LOG2+1)'(w_push) - (DEPTH_LOG2+1)'(w_pop);
            // a drop wins over a same-cycle clear
            r_ovf   <= w_drop || (r_ovf && !w_clr);
            r_alf   <= r_count >= (DEPTH_LOG2+1)'(ALF_THRESH);
            if (w_access && local_rw)
                r_rdata <= w_rdata;
        end

    always_ff @(posedge Clk)
        if (Reset_N)
            r_state <= IDLE;
        else
            r_state <= w_state_nx;

    always_comb
        w_state_nx = r_state == IDLE ? (local_cs_n ? IDLE : ACK)
                   : r_state == ACK  ? WAIT_REL
                   : (local_cs_n ? IDLE : WAIT_REL);

    always_comb
        local_ack_n = r_state != ACK;

    assign local_rdata      = r_rdata;
    assign Evict_in_key_alf = r_alf;
endmodule

// File: doc/evict_sink.md
EVICT_SINK -- requirements
Module: evict_sink

Interface
REQ-001 SHALL have parameter DEPTH_LOG2, default 4, giving a record buffer of 2^DEPTH_LOG2 entries (16).
REQ-002 SHALL have parameter ALF_THRESH, default 12, the occupancy at which almost-full asserts.
REQ-003 SHALL have port Clk, input, 1, the single system clock; all logic rises on its posedge.
REQ-004 SHALL have port Reset_N, input, 1, reset; synchronous and active-high (1 = reset).
REQ-005 SHALL have port Evict_in_key, input, 224, record {KEY[223:96], FREQ[95:64], TIMESTAMP[63:32], VALUE[31:0]} from the last heap stage.
REQ-006 SHALL have port Evict_in_key_wr, input, 1, one-cycle write strobe for Evict_in_key.
REQ-007 SHALL have port Evict_in_key_alf, output, 1, almost-full back-pressure to the upstream stage.
REQ-008 SHALL have port local_cs_n, input, 1, localbus chip select, active low.
REQ-009 SHALL have port local_rw, input, 1, 1 = read, 0 = write.
REQ-010 SHALL have port local_addr, input, 14, localbus word address.
REQ-011 SHALL have port local_wdata, input, 32, localbus write data.
REQ-012 SHALL have port local_rdata, output, 32, localbus read data.
REQ-013 SHALL have port local_ack_n, output, 1, completion strobe, active low.

Function
REQ-014 Push: Evict_in_key_wr=1 stores Evict_in_key at tail if count<DEPTH, or if a pop executes in the same cycle; count updates on the next edge.
REQ-015 Push while full with no same-cycle pop SHALL drop the record; buffer contents and count unchanged.
REQ-016 Evict_in_key_alf SHALL be registered; it is 1 in the cycle after count becomes >= ALF_THRESH and 0 in the cycle after count becomes < ALF_THRESH.
REQ-017 Pointers SHALL wrap modulo 2^DEPTH_LOG2; count width DEPTH_LOG2+1, range 0..DEPTH.
REQ-018 Address map: 0x0 read = {overflow flag[31], 15'b0, count zero-extended to 16 bits}; 0x1..0x7 read = head record 32-bit word (0x1 = bits [223:192] ... 0x7 = bits [31:0]); 0x8 write (any data) = pop; 0x9 read = drop counter, write (any data) = clear drop counter and overflow flag; other addresses read 0, writes ignored.
REQ-019 Reads of 0x1..0x7 while empty SHALL return 0; a pop while empty SHALL be ignored but still acknowledged.
REQ-020 Bus FSM states IDLE, ACK, WAIT_REL: IDLE->ACK when local_cs_n=0 (latch rw/addr/wdata, execute access); ACK->WAIT_REL after one cycle; WAIT_REL->IDLE when local_cs_n=1.
REQ-021 local_ack_n SHALL be 0 for exactly the one cycle spent in ACK, and 1 otherwise; local_rdata SHALL be valid in that cycle and hold until the next access.
REQ-022 A pop SHALL take effect on the edge leaving IDLE, so Evict_in_key_wr in the same cycle sees REQ-014 same-cycle-pop behaviour.
REQ-023 Overflow flag SHALL set on any dropped record and stay set until cleared via 0x9; set and clear in the same cycle -> flag ends set.

Reset
REQ-024 While Reset_N=1 at a clock edge: pointers, count, FSM (IDLE), overflow flag, drop counter cleared; Evict_in_key_alf=0, local_ack_n=1, local_rdata=0.
REQ-025 Reset asserted mid-transaction SHALL abort it with no ack; a host still holding local_cs_n=0 after reset SHALL be served as a new access.
REQ-026 Buffer RAM contents need not be cleared by reset.

Configuration
REQ-027 Macro EVICT_SINK_DROPCNT_EN defined: 32-bit drop counter increments per dropped record, saturating at 0xFFFFFFFF, readable/clearable at 0x9.
REQ-028 Macro undefined: no counter logic; 0x9 reads 0, 0x9 write clears only the overflow flag.

Verification
REQ-029 Reset, then 12 pushes of distinct records -> count reads 12 at 0x0, Evict_in_key_alf=1 one cycle after 12th push.
REQ-030 Push record KEY=0x0123..EF, FREQ=5, TS=0x100, VALUE=7; read 0x1..0x7 -> words match; write 0x8 -> count 0, reading 0x7 returns 0.
REQ-031 Fill 16, push 3 more -> count 16, 0x0 bit31=1, 0x9 = 3 (macro on) or 0 (macro off); write 0x9 -> bit31=0.
REQ-032 Full buffer, pop and push in same cycle -> count stays 16, no drop counted, new record at tail after 15 further pops.
REQ-033 Hold local_cs_n=0 for 10 cycles on a read -> exactly one ack_n low pulse; second access starts only after cs_n returns to 1.
